ex_result_stage: RTL and testbench
==================================

Name: ex_result_stage

Overview:
- Execute-to-memory boundary stage. It consumes the ALU's per-cycle outputs (result, zero, carry, overflow) together with instruction metadata.
- Resolves branch-compare ops into a registered PC redirect and squashes the branch shadow.
- Keeps sticky carry/overflow status.
- Buffers results in a small FIFO toward the memory/writeback stage, using a valid/ready handshake so downstream stalls never corrupt ALU results.

Parameters:
DEPTH, 2, result FIFO entries (power of two, >=2)
BR_SHADOW, 1, number of instructions accepted after a taken branch that are discarded (0..3)
XLEN, 32, datapath width

Ports:
clk  in  1  system clock, all state on rising edge
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  upstream ALU result valid
in_ready  out  1  stage can accept; equals (count < DEPTH)
in_op  in  7  ALU op code of this instruction
in_result  in  XLEN  ALU result
in_zero  in  1  ALU zero flag
in_carry  in  1  ALU carry
in_overflow  in  1  ALU overflow
in_pc  in  XLEN  instruction PC
in_imm  in  XLEN  sign-extended branch offset
in_rd  in  5  destination register
in_wb_en  in  1  instruction writes rd
flush  in  1  external pipeline flush
clr_sticky  in  1  clear sticky flags
out_valid  out  1  FIFO head valid
out_ready  in  1  downstream accepts head
out_result  out  XLEN  head result
out_rd  out  5  head rd
out_wb_en  out  1  head write enable
out_flags  out  3  head {overflow, carry, zero}
redirect_valid  out  1  one-cycle taken-branch pulse
redirect_pc  out  XLEN  branch target
redirect_misalign  out  1  target[1:0] != 0, valid with redirect_valid
sticky_flags  out  2  {overflow, carry} OR-accumulated

Behaviour:
- Reset (async, rst_n=0):
  - FIFO count, read and write pointers = 0; out_valid=0; in_ready=1.
  - redirect_valid=0, redirect_pc=0, redirect_misalign=0.
  - sticky_flags=0, shadow counter=0.
  - Reset mid-operation discards all entries immediately.
- Accept when in_valid && in_ready. Pop when out_valid && out_ready. Push and pop in the same cycle leave count unchanged. in_ready has no combinational path from out_ready.
- Branch ops (0x20 BEQ, 0x21 BNE, 0x22 BLT, 0x23 BGE):
  - taken = in_result[0].
  - Entry is pushed with wb_en forced 0.
  - If taken and not squashed: next cycle redirect_valid=1 for exactly one cycle, redirect_pc = in_pc + in_imm (mod 2^XLEN), redirect_misalign = target[1:0]!=0. Shadow counter loads BR_SHADOW.
- Shadow:
  - While shadow counter > 0, each accepted instruction is dropped (not pushed, no redirect, no sticky update) and the counter decrements.
  - in_ready still follows occupancy.
  - A taken branch inside the shadow is dropped.
- Non-branch ops:
  - Push {result, rd, wb_en, {overflow, carry, zero}}.
  - sticky_flags |= {overflow, carry} on accept.
- clr_sticky:
  - Clears sticky_flags.
  - If asserted in the same cycle as a sticky update, the clear wins for that cycle and the update is lost.
- flush:
  - Synchronous. Empties the FIFO (count=0, pointers=0) and zeroes the shadow counter.
  - Suppresses any pending redirect not yet output; a redirect already high completes its cycle.
  - Input accepted in the flush cycle is dropped.
  - Flush has priority over push and pop.
- Full: in_ready=0; in_valid is ignored. Empty: out_valid=0; output fields hold the last head value.
- Pointers wrap modulo DEPTH.
- Latency: an accepted entry is visible at the output the next cycle when the FIFO was empty. Redirect latency is 1 cycle.

Decomposition:
- Shared package ex_pkg:
  - ALU op code constants (OP_ADD..OP_BGE, including branch range 0x20-0x23).
  - Flag index constants.
  - Entry record width constant (XLEN+5+1+3).
- One sub-module ex_result_fifo: parameterised DEPTH×width synchronous FIFO with count, flush, in_ready/out_valid.
- The top level contains branch resolution, shadow counter and sticky logic.

Test Plan:
1. Reset then ADD (result 0x00000005, rd=3, wb_en=1, out_ready=1) -> next cycle out_valid=1, out_result=0x5, out_rd=3, out_flags=3'b000; sticky_flags=0.
2. out_ready=0, push 3 results 0x11, 0x22, 0x33 -> first two accepted, in_ready=0 on third. Raise out_ready -> drain order 0x11, 0x22, then 0x33 accepted.
3. BEQ taken (in_result=1, in_pc=0x100, in_imm=0x20), next instruction ADD -> redirect_valid one cycle with redirect_pc=0x120, misalign=0. ADD is dropped (BR_SHADOW=1). Branch entry emerges with out_wb_en=0.
4. BLT not taken (in_result=0) -> no redirect; following ADD is pushed normally.
5. ADD with carry=1, then SUB with overflow=1 -> sticky_flags=2'b11. Assert clr_sticky -> 2'b00 next cycle.
6. Two entries buffered, then flush together with in_valid -> count=0, out_valid=0 next cycle, input dropped, in_ready=1.
7. rst_n low mid-stream -> all outputs return to reset values asynchronously.

Source files
------------

// File: rtl/ex_pkg.sv
// Shared definitions for the execute result stage: ALU op codes, flag positions,
// and the width of a buffered result entry.
package ex_pkg;

  localparam logic [6:0] OP_ADD = 7'h00;
  localparam logic [6:0] OP_SUB = 7'h01;
  localparam logic [6:0] OP_AND = 7'h02;
  localparam logic [6:0] OP_OR  = 7'h03;
  localparam logic [6:0] OP_XOR = 7'h04;
  localparam logic [6:0] OP_SLL = 7'h05;
  localparam logic [6:0] OP_SRL = 7'h06;
  localparam logic [6:0] OP_SLT = 7'h07;
  localparam logic [6:0] OP_BEQ = 7'h20;
  localparam logic [6:0] OP_BNE = 7'h21;
  localparam logic [6:0] OP_BLT = 7'h22;
  localparam logic [6:0] OP_BGE = 7'h23;

  localparam int FLAG_ZERO    = 0;
  localparam int FLAG_CARRY   = 1;
  localparam int FLAG_OVF     = 2;
  localparam int STICKY_CARRY = 0;
  localparam int STICKY_OVF   = 1;

  // Entry layout is {result, rd, wb_en, flags}; the non-result part is fixed.
  localparam int XLEN_DEFAULT = 32;
  localparam int ENTRY_META_W = 5 + 1 + 3;
  localparam int ENTRY_W      = XLEN_DEFAULT + ENTRY_META_W;

  function automatic logic is_branch(input logic [6:0] op);
    return (op >= OP_BEQ) && (op <= OP_BGE);
  endfunction

endpackage

// File: rtl/ex_result_fifo.sv
// Small synchronous FIFO with occupancy-based ready, flush, and an output
// that holds the last head value while empty.
module ex_result_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 41
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  output logic             in_ready,
  output logic             out_valid,
  input  logic             pop_ready,
  output logic [WIDTH-1:0] out_data
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [CW-1:0]    count;
  logic [WIDTH-1:0] hold_q;
  logic             do_push;
  logic             do_pop;

  // Ready depends only on occupancy so there is no path from pop_ready.
  assign in_ready  = count < CW'(DEPTH);
  assign out_valid = count != '0;
  assign do_push   = push && in_ready;
  assign do_pop    = out_valid && pop_ready;
  assign out_data  = out_valid ? mem[rd_ptr] : hold_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count  <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (flush) begin
      count  <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_q <= '0;
    end else if (out_valid) begin
      hold_q <= mem[rd_ptr];
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/ex_result_stage.sv
// Execute-to-memory boundary: branch resolution with shadow squash, sticky
// carry/overflow status, and a result FIFO toward writeback.
module ex_result_stage
  import ex_pkg::*;
#(
  parameter int DEPTH     = 2,
  parameter int BR_SHADOW = 1,
  parameter int XLEN      = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [6:0]      in_op,
  input  logic [XLEN-1:0] in_result,
  input  logic            in_zero,
  input  logic            in_carry,
  input  logic            in_overflow,
  input  logic [XLEN-1:0] in_pc,
  input  logic [XLEN-1:0] in_imm,
  input  logic [4:0]      in_rd,
  input  logic            in_wb_en,
  input  logic            flush,
  input  logic            clr_sticky,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_result,
  output logic [4:0]      out_rd,
  output logic            out_wb_en,
  output logic [2:0]      out_flags,
  output logic            redirect_valid,
  output logic [XLEN-1:0] redirect_pc,
  output logic            redirect_misalign,
  output logic [1:0]      sticky_flags
);

  localparam int EW = XLEN + ENTRY_META_W;

  logic [1:0]      shadow_cnt;
  logic            is_br;
  logic            accept;
  logic            keep;
  logic            taken;
  logic [XLEN-1:0] target;
  logic [2:0]      in_flags;
  logic [EW-1:0]   push_data;
  logic [EW-1:0]   head;

  // An accepted instruction survives only outside the shadow and flush.
  assign is_br  = is_branch(in_op);
  assign accept = in_valid && in_ready;
  assign keep   = accept && !flush && (shadow_cnt == 2'd0);
  assign taken  = keep && is_br && in_result[0];
  assign target = in_pc + in_imm;

  assign in_flags[FLAG_ZERO]  = in_zero;
  assign in_flags[FLAG_CARRY] = in_carry;
  assign in_flags[FLAG_OVF]   = in_overflow;
  assign push_data = {in_result, in_rd, in_wb_en && !is_br, in_flags};

  ex_result_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (EW)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .push      (keep),
    .push_data (push_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .pop_ready (out_ready),
    .out_data  (head)
  );

  assign {out_result, out_rd, out_wb_en, out_flags} = head;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      redirect_valid    <= 1'b0;
      redirect_pc       <= '0;
      redirect_misalign <= 1'b0;
    end else begin
      redirect_valid    <= taken;
      redirect_misalign <= taken && (target[1:0] != 2'b00);
      if (taken) redirect_pc <= target;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow_cnt <= 2'd0;
    end else if (flush) begin
      shadow_cnt <= 2'd0;
    end else if (taken) begin
      shadow_cnt <= 2'(BR_SHADOW);
    end else if (accept && shadow_cnt != 2'd0) begin
      shadow_cnt <= shadow_cnt - 2'd1;
    end
  end

  // Clear beats a same-cycle update.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sticky_flags <= 2'b00;
    end else if (clr_sticky) begin
      sticky_flags <= 2'b00;
    end else if (keep && !is_br) begin
      sticky_flags[STICKY_CARRY] <= sticky_flags[STICKY_CARRY] | in_carry;
      sticky_flags[STICKY_OVF]   <= sticky_flags[STICKY_OVF] | in_overflow;
    end
  end

endmodule

// File: tb/tb_ex_result_stage.sv
// Self-checking bench for ex_result_stage: directed scenarios plus a
// randomized run against a queue-based reference model.
module tb_ex_result_stage;

  localparam int XLEN      = 32;
  localparam int DEPTH     = 2;
  localparam int BR_SHADOW = 1;

  logic            clk;
  logic            rst_n;
  logic            in_valid;
  logic            in_ready;
  logic [6:0]      in_op;
  logic [XLEN-1:0] in_result;
  logic            in_zero;
  logic            in_carry;
  logic            in_overflow;
  logic [XLEN-1:0] in_pc;
  logic [XLEN-1:0] in_imm;
  logic [4:0]      in_rd;
  logic            in_wb_en;
  logic            flush;
  logic            clr_sticky;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] out_result;
  logic [4:0]      out_rd;
  logic            out_wb_en;
  logic [2:0]      out_flags;
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;
  logic            redirect_misalign;
  logic [1:0]      sticky_flags;

  int checks;
  int errors;

  ex_result_stage #(
    .DEPTH     (DEPTH),
    .BR_SHADOW (BR_SHADOW),
    .XLEN      (XLEN)
  ) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .in_valid          (in_valid),
    .in_ready          (in_ready),
    .in_op             (in_op),
    .in_result         (in_result),
    .in_zero           (in_zero),
    .in_carry          (in_carry),
    .in_overflow       (in_overflow),
    .in_pc             (in_pc),
    .in_imm            (in_imm),
    .in_rd             (in_rd),
    .in_wb_en          (in_wb_en),
    .flush             (flush),
    .clr_sticky        (clr_sticky),
    .out_valid         (out_valid),
    .out_ready         (out_ready),
    .out_result        (out_result),
    .out_rd            (out_rd),
    .out_wb_en         (out_wb_en),
    .out_flags         (out_flags),
    .redirect_valid    (redirect_valid),
    .redirect_pc       (redirect_pc),
    .redirect_misalign (redirect_misalign),
    .sticky_flags      (sticky_flags)
  );

  always #5 clk = ~clk;

  // Reference model state: queued entries, shadow budget, sticky, redirect.
  typedef struct packed {
    logic [XLEN-1:0] res;
    logic [4:0]      rd;
    logic            wb;
    logic [2:0]      f;
  } ent_t;

  ent_t            m_q[$];
  int              m_shadow;
  logic [1:0]      m_sticky;
  logic            m_rv;
  logic [XLEN-1:0] m_rpc;
  logic            m_mis;

  task automatic set_in(input logic v, input logic [6:0] op, input logic [31:0] res,
                        input logic [31:0] pc, input logic [31:0] imm,
                        input logic [4:0] rd, input logic wb, input logic [2:0] f);
    in_valid    = v;
    in_op       = op;
    in_result   = res;
    in_pc       = pc;
    in_imm      = imm;
    in_rd       = rd;
    in_wb_en    = wb;
    {in_overflow, in_carry, in_zero} = f;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    m_q.delete();
    m_shadow = 0;
    m_sticky = 2'b00;
    m_rv     = 1'b0;
    m_rpc    = '0;
    m_mis    = 1'b0;
  endtask

  // Advance the model by one clock using the inputs currently driven.
  task automatic model_step();
    bit              acc;
    bit              br;
    logic [XLEN-1:0] tgt;
    ent_t            e;
    acc = in_valid && (m_q.size() < DEPTH);
    br  = (in_op == 7'h20) || (in_op == 7'h21) || (in_op == 7'h22) || (in_op == 7'h23);
    tgt = in_pc + in_imm;
    m_rv  = 1'b0;
    m_mis = 1'b0;
    if (flush) begin
      m_q.delete();
      m_shadow = 0;
    end else begin
      if (m_q.size() > 0 && out_ready) void'(m_q.pop_front());
      if (acc) begin
        if (m_shadow > 0) begin
          m_shadow--;
        end else begin
          e.res = in_result;
          e.rd  = in_rd;
          e.wb  = br ? 1'b0 : in_wb_en;
          e.f   = {in_overflow, in_carry, in_zero};
          m_q.push_back(e);
          if (!br) m_sticky = m_sticky | {in_overflow, in_carry};
          if (br && in_result[0]) begin
            m_rv     = 1'b1;
            m_rpc    = tgt;
            m_mis    = (tgt % 4) != 0;
            m_shadow = BR_SHADOW;
          end
        end
      end
    end
    if (clr_sticky) m_sticky = 2'b00;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_out_valid got %0b want 0", out_valid); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL reset_in_ready got %0b want 1", in_ready); end
    checks++; if (redirect_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_redirect_valid got %0b want 0", redirect_valid); end
    checks++; if (redirect_pc !== 32'h0) begin errors++; $display("[TB] FAIL reset_redirect_pc got %h want 0", redirect_pc); end
    checks++; if (redirect_misalign !== 1'b0) begin errors++; $display("[TB] FAIL reset_misalign got %0b want 0", redirect_misalign); end
    checks++; if (sticky_flags !== 2'b00) begin errors++; $display("[TB] FAIL reset_sticky got %b want 00", sticky_flags); end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_single_add();
    out_ready = 1'b1;
    set_in(1'b1, 7'h00, 32'h5, 32'h0, 32'h0, 5'd3, 1'b1, 3'b000);
    tick();
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b1) begin errors++; $display("[TB] FAIL add_valid got %0b want 1", out_valid); end
    checks++; if (out_result !== 32'h5) begin errors++; $display("[TB] FAIL add_result got %h want 5", out_result); end
    checks++; if (out_rd !== 5'd3) begin errors++; $display("[TB] FAIL add_rd got %0d want 3", out_rd); end
    checks++; if (out_wb_en !== 1'b1) begin errors++; $display("[TB] FAIL add_wb got %0b want 1", out_wb_en); end
    checks++; if (out_flags !== 3'b000) begin errors++; $display("[TB] FAIL add_flags got %b want 000", out_flags); end
    checks++; if (sticky_flags !== 2'b00) begin errors++; $display("[TB] FAIL add_sticky got %b want 00", sticky_flags); end
    tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL add_drained got %0b want 0", out_valid); end
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    set_in(1'b1, 7'h00, 32'h11, 32'h0, 32'h0, 5'd1, 1'b1, 3'b000);
    tick();
    in_result = 32'h22;
    tick();
    in_result = 32'h33;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("[TB] FAIL bp_full_ready got %0b want 0", in_ready); end
    tick();
    checks++; if (out_result !== 32'h11) begin errors++; $display("[TB] FAIL bp_head0 got %h want 11", out_result); end
    out_ready = 1'b1;
    tick();
    checks++; if (out_result !== 32'h22) begin errors++; $display("[TB] FAIL bp_head1 got %h want 22", out_result); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL bp_ready_again got %0b want 1", in_ready); end
    tick();
    in_valid = 1'b0;
    checks++; if (out_result !== 32'h33 || out_valid !== 1'b1) begin errors++; $display("[TB] FAIL bp_head2 got %h/%0b want 33/1", out_result, out_valid); end
    tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL bp_empty got %0b want 0", out_valid); end
  endtask

  task automatic test_branch_taken();
    out_ready = 1'b0;
    set_in(1'b1, 7'h20, 32'h1, 32'h100, 32'h20, 5'd5, 1'b1, 3'b000);
    tick();
    in_valid = 1'b0;
    checks++; if (redirect_valid !== 1'b1) begin errors++; $display("[TB] FAIL br_redirect got %0b want 1", redirect_valid); end
    checks++; if (redirect_pc !== 32'h120) begin errors++; $display("[TB] FAIL br_target got %h want 120", redirect_pc); end
    checks++; if (redirect_misalign !== 1'b0) begin errors++; $display("[TB] FAIL br_misalign got %0b want 0", redirect_misalign); end
    checks++; if (out_valid !== 1'b1 || out_wb_en !== 1'b0) begin errors++; $display("[TB] FAIL br_entry got v%0b wb%0b want v1 wb0", out_valid, out_wb_en); end
    set_in(1'b1, 7'h00, 32'h77, 32'h104, 32'h0, 5'd2, 1'b1, 3'b000);
    tick();
    in_valid = 1'b0;
    checks++; if (redirect_valid !== 1'b0) begin errors++; $display("[TB] FAIL br_one_cycle got %0b want 0", redirect_valid); end
    out_ready = 1'b1;
    tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL br_shadow_drop got %0b want 0", out_valid); end
    set_in(1'b1, 7'h21, 32'h1, 32'h200, 32'h6, 5'd0, 1'b0, 3'b000);
    tick();
    in_valid = 1'b0;
    checks++; if (redirect_valid !== 1'b1 || redirect_pc !== 32'h206) begin errors++; $display("[TB] FAIL bne_target got %0b/%h want 1/206", redirect_valid, redirect_pc); end
    checks++; if (redirect_misalign !== 1'b1) begin errors++; $display("[TB] FAIL bne_misalign got %0b want 1", redirect_misalign); end
    tick();
    set_in(1'b1, 7'h00, 32'h55, 32'h0, 32'h0, 5'd4, 1'b1, 3'b000);
    tick();
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL shadow_idle_drop got %0b want 0", out_valid); end
    tick();
  endtask

  task automatic test_not_taken();
    out_ready = 1'b1;
    set_in(1'b1, 7'h22, 32'h0, 32'h100, 32'h40, 5'd6, 1'b1, 3'b000);
    tick();
    checks++; if (redirect_valid !== 1'b0) begin errors++; $display("[TB] FAIL nt_redirect got %0b want 0", redirect_valid); end
    checks++; if (out_valid !== 1'b1 || out_wb_en !== 1'b0) begin errors++; $display("[TB] FAIL nt_entry got v%0b wb%0b want v1 wb0", out_valid, out_wb_en); end
    set_in(1'b1, 7'h00, 32'h44, 32'h0, 32'h0, 5'd7, 1'b1, 3'b000);
    tick();
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b1 || out_result !== 32'h44) begin errors++; $display("[TB] FAIL nt_next got %0b/%h want 1/44", out_valid, out_result); end
    checks++; if (out_rd !== 5'd7 || out_wb_en !== 1'b1) begin errors++; $display("[TB] FAIL nt_next_meta got %0d/%0b want 7/1", out_rd, out_wb_en); end
    tick();
  endtask

  task automatic test_sticky();
    out_ready = 1'b1;
    set_in(1'b1, 7'h00, 32'h1, 32'h0, 32'h0, 5'd1, 1'b1, 3'b010);
    tick();
    checks++; if (sticky_flags !== 2'b01) begin errors++; $display("[TB] FAIL sticky_carry got %b want 01", sticky_flags); end
    set_in(1'b1, 7'h01, 32'h2, 32'h0, 32'h0, 5'd1, 1'b1, 3'b100);
    tick();
    in_valid = 1'b0;
    checks++; if (sticky_flags !== 2'b11) begin errors++; $display("[TB] FAIL sticky_both got %b want 11", sticky_flags); end
    checks++; if (out_flags !== 3'b100) begin errors++; $display("[TB] FAIL sub_flags got %b want 100", out_flags); end
    clr_sticky = 1'b1;
    tick();
    checks++; if (sticky_flags !== 2'b00) begin errors++; $display("[TB] FAIL sticky_clear got %b want 00", sticky_flags); end
    set_in(1'b1, 7'h00, 32'h3, 32'h0, 32'h0, 5'd1, 1'b1, 3'b010);
    tick();
    in_valid   = 1'b0;
    clr_sticky = 1'b0;
    tick();
    checks++; if (sticky_flags !== 2'b00) begin errors++; $display("[TB] FAIL sticky_clear_wins got %b want 00", sticky_flags); end
  endtask

  task automatic test_flush();
    out_ready = 1'b0;
    set_in(1'b1, 7'h00, 32'hA1, 32'h0, 32'h0, 5'd1, 1'b1, 3'b000);
    tick();
    in_result = 32'hA2;
    tick();
    checks++; if (out_valid !== 1'b1 || in_ready !== 1'b0) begin errors++; $display("[TB] FAIL flush_pre got v%0b r%0b want v1 r0", out_valid, in_ready); end
    flush = 1'b1;
    in_result = 32'hA3;
    tick();
    flush    = 1'b0;
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("[TB] FAIL flush_empty got v%0b r%0b want v0 r1", out_valid, in_ready); end
    tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL flush_input_dropped got %0b want 0", out_valid); end
    out_ready = 1'b1;
    flush = 1'b1;
    set_in(1'b1, 7'h20, 32'h1, 32'h400, 32'h8, 5'd0, 1'b0, 3'b000);
    tick();
    flush = 1'b0;
    set_in(1'b1, 7'h00, 32'hB1, 32'h0, 32'h0, 5'd9, 1'b1, 3'b000);
    checks++; if (redirect_valid !== 1'b0) begin errors++; $display("[TB] FAIL flush_kills_redirect got %0b want 0", redirect_valid); end
    tick();
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b1 || out_result !== 32'hB1) begin errors++; $display("[TB] FAIL flush_no_shadow got %0b/%h want 1/b1", out_valid, out_result); end
    tick();
  endtask

  task automatic test_async_reset();
    out_ready = 1'b0;
    set_in(1'b1, 7'h00, 32'h9, 32'h0, 32'h0, 5'd1, 1'b1, 3'b010);
    tick();
    set_in(1'b1, 7'h20, 32'h1, 32'h300, 32'h4, 5'd0, 1'b0, 3'b000);
    tick();
    in_valid = 1'b0;
    checks++; if (redirect_valid !== 1'b1 || sticky_flags !== 2'b01 || out_valid !== 1'b1) begin errors++; $display("[TB] FAIL arst_pre got r%0b s%b v%0b want r1 s01 v1", redirect_valid, sticky_flags, out_valid); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("[TB] FAIL arst_fifo got v%0b r%0b want v0 r1", out_valid, in_ready); end
    checks++; if (redirect_valid !== 1'b0 || redirect_pc !== 32'h0 || redirect_misalign !== 1'b0) begin errors++; $display("[TB] FAIL arst_redirect got %0b/%h/%0b want 0/0/0", redirect_valid, redirect_pc, redirect_misalign); end
    checks++; if (sticky_flags !== 2'b00) begin errors++; $display("[TB] FAIL arst_sticky got %b want 00", sticky_flags); end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_random();
    logic [6:0]      ops [8];
    logic [XLEN-1:0] r;
    ent_t            got;
    ops = '{7'h00, 7'h01, 7'h02, 7'h03, 7'h20, 7'h21, 7'h22, 7'h23};
    rst_n = 1'b0;
    #1;
    rst_n = 1'b1;
    model_reset();
    tick();
    for (int i = 0; i < 600; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      in_op     = ops[$urandom_range(0, 7)];
      in_result = $urandom;
      r         = $urandom;
      in_pc     = r & 32'hFFFF_FFFC;
      in_imm    = ($urandom_range(0, 1) != 0) ? 32'($urandom_range(0, 64)) : -32'($urandom_range(0, 64));
      in_rd     = 5'($urandom_range(0, 31));
      in_wb_en  = 1'($urandom_range(0, 1));
      {in_overflow, in_carry, in_zero} = 3'($urandom_range(0, 7));
      out_ready  = ($urandom_range(0, 3) != 0);
      flush      = ($urandom_range(0, 19) == 0);
      clr_sticky = ($urandom_range(0, 9) == 0);
      checks++; if (in_ready !== 1'(m_q.size() < DEPTH)) begin errors++; $display("[TB] FAIL rnd_in_ready cyc %0d got %0b want %0b", i, in_ready, m_q.size() < DEPTH); end
      model_step();
      tick();
      checks++; if (out_valid !== 1'(m_q.size() > 0)) begin errors++; $display("[TB] FAIL rnd_out_valid cyc %0d got %0b want %0b", i, out_valid, m_q.size() > 0); end
      if (m_q.size() > 0) begin
        got = {out_result, out_rd, out_wb_en, out_flags};
        checks++; if (got !== m_q[0]) begin errors++; $display("[TB] FAIL rnd_head cyc %0d got %h want %h", i, got, m_q[0]); end
      end
      checks++; if (redirect_valid !== m_rv) begin errors++; $display("[TB] FAIL rnd_redirect cyc %0d got %0b want %0b", i, redirect_valid, m_rv); end
      if (m_rv) begin
        checks++; if (redirect_pc !== m_rpc || redirect_misalign !== m_mis) begin errors++; $display("[TB] FAIL rnd_target cyc %0d got %h/%0b want %h/%0b", i, redirect_pc, redirect_misalign, m_rpc, m_mis); end
      end
      checks++; if (sticky_flags !== m_sticky) begin errors++; $display("[TB] FAIL rnd_sticky cyc %0d got %b want %b", i, sticky_flags, m_sticky); end
    end
    in_valid   = 1'b0;
    flush      = 1'b0;
    clr_sticky = 1'b0;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    checks     = 0;
    errors     = 0;
    clk        = 1'b0;
    rst_n      = 1'b0;
    out_ready  = 1'b0;
    flush      = 1'b0;
    clr_sticky = 1'b0;
    set_in(1'b0, 7'h00, 32'h0, 32'h0, 32'h0, 5'd0, 1'b0, 3'b000);
    test_reset();
    test_single_add();
    test_backpressure();
    test_branch_taken();
    test_not_taken();
    test_sticky();
    test_flush();
    test_async_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
